// File: rtl/vram_arbiter.sv
// Single-port SRAM arbiter: video scanout fetches (with a one-entry pending slot) and MCU writes.
// Define VRAM_MCU_READ_EN to let idle cycles perform MCU read-back of memoryReadAddress.
module vram_arbiter #(
  parameter int unsigned WRITE_PULSE_CYCLES = 2
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        videoReadRequest,
  input  logic [16:0] videoReadAddress,
  output logic [7:0]  videoReadData,
  output logic        videoReadValid,
  output logic        videoDropped,
  input  logic        memoryWriteRequest,
  input  logic [16:0] memoryWriteAddress,
  input  logic [7:0]  memoryWriteData,
  output logic        memoryWriteComplete,
  input  logic [16:0] memoryReadAddress,
  output logic [7:0]  memoryReadData,
  output logic [16:0] sramAddress,
  inout  wire  [7:0]  sramData,
  output logic        sramWriteEnableN,
  output logic        sramOutputEnableN
);

  typedef enum logic [2:0] {StIdle, StVRead, StWSetup, StWPulse, StWHold} state_e;

  localparam logic [3:0] PulseLast = 4'(WRITE_PULSE_CYCLES - 1);

  state_e      state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic [16:0] pend_addr_q, pend_addr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [16:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        drive_q, drive_d;
  logic        we_n_q, we_n_d;
  logic        oe_n_q, oe_n_d;
  logic [7:0]  vdata_q, vdata_d;
  logic        vvalid_q, vvalid_d;
  logic        drop_q, drop_d;
  logic        done_q, done_d;
  logic [7:0]  mrdata_q, mrdata_d;

`ifndef VRAM_MCU_READ_EN
  logic unused_rd_addr;
  assign unused_rd_addr = ^memoryReadAddress;
`endif

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    drive_d      = drive_q;
    we_n_d       = 1'b1;
    oe_n_d       = 1'b1;
    vdata_d      = vdata_q;
    vvalid_d     = 1'b0;
    drop_d       = 1'b0;
    done_d       = 1'b0;
`ifdef VRAM_MCU_READ_EN
    mrdata_d     = mrdata_q;
`else
    mrdata_d     = 8'hFF;
`endif

    case (state_q)
      StIdle: begin
`ifdef VRAM_MCU_READ_EN
        // OE is only low in IDLE when the previous idle cycle set up a read-back
        if (!oe_n_q) mrdata_d = sramData;
`endif
        if (videoReadRequest) begin
          state_d = StVRead;
          addr_d  = videoReadAddress;
          oe_n_d  = 1'b0;
        end else if (pend_valid_q) begin
          state_d      = StVRead;
          addr_d       = pend_addr_q;
          oe_n_d       = 1'b0;
          pend_valid_d = 1'b0;
        end else if (memoryWriteRequest && !done_q) begin
          // done_q masks the requester's late drop so the write is not repeated
          state_d = StWSetup;
          addr_d  = memoryWriteAddress;
          wdata_d = memoryWriteData;
          drive_d = 1'b1;
        end else begin
`ifdef VRAM_MCU_READ_EN
          addr_d = memoryReadAddress;
          oe_n_d = 1'b0;
`endif
        end
      end
      StVRead: begin
        vdata_d  = sramData;
        vvalid_d = 1'b1;
        state_d  = StIdle;
      end
      StWSetup: begin
        we_n_d  = 1'b0;
        cnt_d   = 4'd0;
        state_d = StWPulse;
      end
      StWPulse: begin
        if (cnt_q == PulseLast) begin
          cnt_d   = 4'd0;
          state_d = StWHold;
        end else begin
          we_n_d = 1'b0;
          cnt_d  = cnt_q + 4'd1;
        end
      end
      StWHold: begin
        drive_d = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A live request is always consumed in IDLE, so only busy states park it
    if (state_q != StIdle && videoReadRequest) begin
      pend_addr_d  = videoReadAddress;
      pend_valid_d = 1'b1;
      drop_d       = pend_valid_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q      <= StIdle;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 17'd0;
      cnt_q        <= 4'd0;
      addr_q       <= 17'd0;
      wdata_q      <= 8'd0;
      drive_q      <= 1'b0;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      vdata_q      <= 8'd0;
      vvalid_q     <= 1'b0;
      drop_q       <= 1'b0;
      done_q       <= 1'b0;
      mrdata_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      drive_q      <= drive_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
      vdata_q      <= vdata_d;
      vvalid_q     <= vvalid_d;
      drop_q       <= drop_d;
      done_q       <= done_d;
      mrdata_q     <= mrdata_d;
    end
  end

  assign sramData            = drive_q ? wdata_q : 8'bz;
  assign sramAddress         = addr_q;
  assign sramWriteEnableN    = we_n_q;
  assign sramOutputEnableN   = oe_n_q;
  assign videoReadData       = vdata_q;
  assign videoReadValid      = vvalid_q;
  assign videoDropped        = drop_q;
  assign memoryWriteComplete = done_q;
  assign memoryReadData      = mrdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed vector table, multi-cycle sequences and a
// randomized phase scored against a transaction-level model with a behavioural SRAM.
module tb_vram_arbiter;

  localparam int unsigned WP = 2;

  logic        clock = 1'b0;
  logic        resetN;
  logic        videoReadRequest;
  logic [16:0] videoReadAddress;
  logic [7:0]  videoReadData;
  logic        videoReadValid;
  logic        videoDropped;
  logic        memoryWriteRequest;
  logic [16:0] memoryWriteAddress;
  logic [7:0]  memoryWriteData;
  logic        memoryWriteComplete;
  logic [16:0] memoryReadAddress;
  logic [7:0]  memoryReadData;
  logic [16:0] sramAddress;
  wire  [7:0]  sramData;
  logic        sramWriteEnableN;
  logic        sramOutputEnableN;

  vram_arbiter #(.WRITE_PULSE_CYCLES(WP)) dut (
    .clock               (clock),
    .resetN              (resetN),
    .videoReadRequest    (videoReadRequest),
    .videoReadAddress    (videoReadAddress),
    .videoReadData       (videoReadData),
    .videoReadValid      (videoReadValid),
    .videoDropped        (videoDropped),
    .memoryWriteRequest  (memoryWriteRequest),
    .memoryWriteAddress  (memoryWriteAddress),
    .memoryWriteData     (memoryWriteData),
    .memoryWriteComplete (memoryWriteComplete),
    .memoryReadAddress   (memoryReadAddress),
    .memoryReadData      (memoryReadData),
    .sramAddress         (sramAddress),
    .sramData            (sramData),
    .sramWriteEnableN    (sramWriteEnableN),
    .sramOutputEnableN   (sramOutputEnableN)
  );

  always #5 clock = ~clock;

  // Asynchronous SRAM model
  logic [7:0] mem [0:131071];
  assign sramData = !sramOutputEnableN ? mem[sramAddress] : 8'bz;
  always @(posedge clock) if (!sramWriteEnableN) mem[sramAddress] = sramData;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input logic [16:0] a);
    return a[7:0] ^ a[15:8] ^ {7'd0, a[16]};
  endfunction

  task automatic init_mem();
    for (int i = 0; i < 131072; i++) mem[i] = pat(17'(i));
  endtask

  // Event counters and the OE/WE exclusion check, sampled mid-cycle
  int   we_low_cnt = 0, we_falls = 0, done_cnt = 0, drop_cnt = 0, valid_cnt = 0;
  logic we_prev = 1'b1;
  always @(negedge clock) begin
    if (!sramWriteEnableN) we_low_cnt++;
    if (!sramWriteEnableN && we_prev) we_falls++;
    we_prev = sramWriteEnableN;
    if (memoryWriteComplete) done_cnt++;
    if (videoDropped) drop_cnt++;
    if (videoReadValid) valid_cnt++;
    if (resetN) check("oe_we_overlap", 32'(!sramOutputEnableN && !sramWriteEnableN), 32'd0);
  end

  task automatic do_read(input logic [16:0] a, input logic [7:0] d, input string nm);
    videoReadRequest = 1'b1;
    videoReadAddress = a;
    @(posedge clock); #1;
    videoReadRequest = 1'b0;
    check({nm, "_valid_during_vread"}, 32'(videoReadValid), 32'd0);
    check({nm, "_vread_addr"}, 32'(sramAddress), 32'(a));
    check({nm, "_vread_oe"}, 32'(sramOutputEnableN), 32'd0);
    @(posedge clock); #1;
    check({nm, "_valid"}, 32'(videoReadValid), 32'd1);
    check({nm, "_data"}, 32'(videoReadData), 32'(d));
  endtask

  task automatic do_write(input logic [16:0] a, input logic [7:0] d, input string nm);
    int n, we0, fall0, done0;
    we0 = we_low_cnt; fall0 = we_falls; done0 = done_cnt;
    memoryWriteRequest = 1'b1;
    memoryWriteAddress = a;
    memoryWriteData    = d;
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!memoryWriteComplete && n < 40);
    check({nm, "_complete_latency"}, 32'(n), 32'(WP + 3));
    // requester drops one cycle late; the arbiter must not start a second write
    @(posedge clock); #1;
    memoryWriteRequest = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check({nm, "_we_low_cycles"}, 32'(we_low_cnt - we0), 32'(WP));
    check({nm, "_single_write"}, 32'(we_falls - fall0), 32'd1);
    check({nm, "_complete_pulses"}, 32'(done_cnt - done0), 32'd1);
    check({nm, "_sram_content"}, 32'(mem[a]), 32'(d));
  endtask

  // Write with video requests issued lead edges after the write request
  task automatic write_with_video(input logic [16:0] wa, input logic [7:0] wd, input int lead,
                                  input logic [16:0] va0, input logic [16:0] va1,
                                  input int nreq, input logic [7:0] vexp, input string nm);
    int k, c_at, v_at, nval, drop0, fall0, done0;
    drop0 = drop_cnt; fall0 = we_falls; done0 = done_cnt;
    memoryWriteRequest = 1'b1;
    memoryWriteAddress = wa;
    memoryWriteData    = wd;
    repeat (lead) @(posedge clock);
    #1;
    for (int r = 0; r < nreq; r++) begin
      videoReadRequest = 1'b1;
      videoReadAddress = (r == 0) ? va0 : va1;
      @(posedge clock); #1;
    end
    videoReadRequest = 1'b0;
    k = 0; c_at = -1; v_at = -1; nval = 0;
    while (k < 20) begin
      @(posedge clock); #1;
      k++;
      if (memoryWriteRequest && c_at >= 0) memoryWriteRequest = 1'b0;
      else if (memoryWriteComplete) c_at = k;
      if (videoReadValid) begin
        nval++;
        if (v_at < 0) v_at = k;
        check({nm, "_fetch_data"}, 32'(videoReadData), 32'(vexp));
      end
    end
    check({nm, "_write_completed"}, 32'(c_at >= 0), 32'd1);
    check({nm, "_fetch_latency_ok"}, 32'(v_at >= 1 && v_at <= int'(WP) + 3), 32'd1);
    check({nm, "_fetch_count"}, 32'(nval), 32'd1);
    check({nm, "_drops"}, 32'(drop_cnt - drop0), 32'(nreq - 1));
    check({nm, "_single_write"}, 32'(we_falls - fall0), 32'd1);
    check({nm, "_complete_pulses"}, 32'(done_cnt - done0), 32'd1);
    check({nm, "_sram_content"}, 32'(mem[wa]), 32'(wd));
  endtask

  typedef struct {
    logic        is_write;
    logic        preload;
    logic [16:0] addr;
    logic [7:0]  data;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_q [$];
    int n_req, n_val, n_drop, n_wr, we0, fall0, done0, v0, d0, idx;
    logic w_done_seen;

    vecs[0] = '{is_write: 1'b0, preload: 1'b1, addr: 17'h00100, data: 8'h5A};
    vecs[1] = '{is_write: 1'b1, preload: 1'b0, addr: 17'h1FFFF, data: 8'hC3};
    vecs[2] = '{is_write: 1'b0, preload: 1'b0, addr: 17'h1FFFF, data: 8'hC3};
    vecs[3] = '{is_write: 1'b0, preload: 1'b1, addr: 17'h00000, data: 8'h00};
    vecs[4] = '{is_write: 1'b0, preload: 1'b1, addr: 17'h0FFFF, data: 8'hFF};
    vecs[5] = '{is_write: 1'b0, preload: 1'b1, addr: 17'h12345, data: 8'h81};
    vecs[6] = '{is_write: 1'b1, preload: 1'b0, addr: 17'h10000, data: 8'h00};
    vecs[7] = '{is_write: 1'b0, preload: 1'b0, addr: 17'h10000, data: 8'h00};

    init_mem();
    resetN             = 1'b0;
    videoReadRequest   = 1'b1;
    videoReadAddress   = 17'h00300;
    memoryWriteRequest = 1'b0;
    memoryWriteAddress = 17'd0;
    memoryWriteData    = 8'd0;
    memoryReadAddress  = 17'd0;

    // Reset values, with a video request held throughout that must be discarded
    repeat (3) @(posedge clock);
    #1;
    check("rst_we_n", 32'(sramWriteEnableN), 32'd1);
    check("rst_oe_n", 32'(sramOutputEnableN), 32'd1);
    check("rst_sram_addr", 32'(sramAddress), 32'd0);
    check("rst_vdata", 32'(videoReadData), 32'd0);
    check("rst_mrdata", 32'(memoryReadData), 32'd0);
    check("rst_pulses", 32'({videoReadValid, videoDropped, memoryWriteComplete}), 32'd0);
    videoReadRequest = 1'b0;
    resetN           = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("rst_request_discarded", 32'(valid_cnt + drop_cnt), 32'd0);
`ifndef VRAM_MCU_READ_EN
    check("mrdata_constant_ff", 32'(memoryReadData), 32'hFF);
`endif

    // Vector table; consecutive reads are issued every second cycle
    v0 = valid_cnt; d0 = drop_cnt;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_write) begin
        do_write(vecs[i].addr, vecs[i].data, $sformatf("vec%0d_wr", i));
      end else begin
        if (vecs[i].preload) mem[vecs[i].addr] = vecs[i].data;
        do_read(vecs[i].addr, vecs[i].data, $sformatf("vec%0d_rd", i));
      end
    end
    repeat (2) @(posedge clock);
    #1;
    check("table_valid_count", 32'(valid_cnt - v0), 32'd6);
    check("table_no_drops", 32'(drop_cnt - d0), 32'd0);

`ifndef VRAM_MCU_READ_EN
    check("idle_addr_held", 32'(sramAddress), 32'h10000);
    check("idle_oe_high", 32'(sramOutputEnableN), 32'd1);
`endif

    // Video request during the write pulse
    mem[17'h00200] = 8'h11;
    write_with_video(17'h1ABCD, 8'h96, 2, 17'h00200, 17'h00200, 1, 8'h11, "vid_in_wpulse");

    // Two requests during one write: the first is overwritten
    mem[17'h00010] = 8'hAA;
    mem[17'h00020] = 8'hBB;
    write_with_video(17'h1BEEF, 8'h5C, 1, 17'h00010, 17'h00020, 2, 8'hBB, "two_vid_in_write");

    // Reset during the write pulse
    done0 = done_cnt;
    memoryWriteRequest = 1'b1;
    memoryWriteAddress = 17'h15555;
    memoryWriteData    = 8'h3C;
    repeat (2) @(posedge clock);
    #1;
    check("midrst_we_low_before", 32'(sramWriteEnableN), 32'd0);
    resetN = 1'b0;
    @(posedge clock); #1;
    check("midrst_we_high", 32'(sramWriteEnableN), 32'd1);
    check("midrst_oe_high", 32'(sramOutputEnableN), 32'd1);
    check("midrst_no_complete", 32'(memoryWriteComplete), 32'd0);
    memoryWriteRequest = 1'b0;
    @(posedge clock); #1;
    resetN = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check("midrst_no_complete_after", 32'(done_cnt - done0), 32'd0);
    // A driven bus left over from the aborted write would corrupt this fetch
    mem[17'h00555] = 8'h6D;
    do_read(17'h00555, 8'h6D, "midrst_bus_released");

`ifdef VRAM_MCU_READ_EN
    mem[17'h00042]    = 8'h77;
    memoryReadAddress = 17'h00042;
    repeat (2) @(posedge clock);
    #1;
    check("mcu_readback", 32'(memoryReadData), 32'h77);
    memoryReadAddress = 17'd0;
`else
    check("mcu_readback_disabled", 32'(memoryReadData), 32'hFF);
`endif

    // Randomized traffic: video reads in the low half, writes in the high half
    init_mem();
    n_req = 0; n_val = 0; n_drop = 0; n_wr = 0; w_done_seen = 1'b0;
    we0 = we_low_cnt; fall0 = we_falls;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clock); #1;
      if (videoReadValid) begin
        idx = -1;
        for (int j = 0; j < exp_q.size(); j++) if (idx < 0 && exp_q[j] == videoReadData) idx = j;
        check("rand_fetch_matches_request", 32'(idx >= 0), 32'd1);
        if (idx >= 0) exp_q.delete(idx);
        n_val++;
      end
      if (videoDropped) n_drop++;
      if (w_done_seen) begin
        memoryWriteRequest = 1'b0;
        w_done_seen        = 1'b0;
      end else if (memoryWriteRequest && memoryWriteComplete) begin
        check("rand_write_content", 32'(mem[memoryWriteAddress]), 32'(memoryWriteData));
        w_done_seen = 1'b1;
        n_wr++;
      end else if (!memoryWriteRequest && cyc < 560 && $urandom_range(0, 7) == 0) begin
        memoryWriteRequest = 1'b1;
        memoryWriteAddress = 17'h10000 | 17'($urandom_range(0, 32'hFFFF));
        memoryWriteData    = 8'($urandom);
      end
      if (cyc < 560 && $urandom_range(0, 3) == 0) begin
        videoReadRequest = 1'b1;
        videoReadAddress = 17'($urandom_range(0, 32'hFFFF));
        exp_q.push_back(pat(videoReadAddress));
        n_req++;
      end else begin
        videoReadRequest = 1'b0;
      end
    end
    check("rand_requests_accounted", 32'(n_req), 32'(n_val + n_drop));
    check("rand_unserved_equals_drops", 32'(exp_q.size()), 32'(n_drop));
    check("rand_writes_seen", 32'(n_wr > 0), 32'd1);
    check("rand_we_low_cycles", 32'(we_low_cnt - we0), 32'(int'(WP) * n_wr));
    check("rand_single_writes", 32'(we_falls - fall0), 32'(n_wr));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
